// File: rtl/ss_correlator_multi.sv
// ---------------------------------------------------------------------------
// ss_correlator_multi
//   Multi-channel spread-spectrum correlator on a 32-bit memory-mapped bus.
//   Each channel runs a carrier DDS with a quarter-wave sine lookup, a chip
//   DDS that clocks a Galois LFSR PRN generator, and a 64-bit
//   multiply-accumulate. At every PRN epoch the integrate-and-dump result is
//   latched and flagged.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   addr            bus address
//   Wdata           bus write data
//   write / read    one-cycle access strobes
//   Rdata           combinational read data (0 when idle or unmapped)
//   ADC             signed sample, qualified by PushADC
//   PushADC         sample strobe
//   CorrelationSeen per-channel epoch-seen flags (mirror of SEEN)
// ---------------------------------------------------------------------------
module ss_correlator_multi #(
   parameter int          NCH    = 4,
   parameter int          ADC_W  = 16,
   parameter int          LFSR_W = 14,
   parameter logic [31:0] BASE   = 32'hFE000100
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             addr,
   input  logic [31:0]             Wdata,
   input  logic                    write,
   input  logic                    read,
   output logic [31:0]             Rdata,
   input  logic signed [ADC_W-1:0] ADC,
   input  logic                    PushADC,
   output logic [NCH-1:0]          CorrelationSeen
);

   // Quarter-wave sine, Bhaskara approximation sampled at the bin centre:
   // angle = (v + 0.5) * (pi/2) / 8192, amplitude 32767. Bin 0 yields 3.
   function automatic logic [15:0] sine_f(input int v);
      longint p, q, num, den;
      p   = 2 * longint'(v) + 1;
      q   = p * (64'sd32768 - p);
      num = 64'sd524272 * q;
      den = 64'sd5368709120 - 64'sd4 * q;
      return 16'(num / den);
   endfunction

   genvar gi;

   logic [15:0] sine_rom [8192];
   for (gi = 0; gi < 8192; gi++) begin : g_sine
      localparam logic [15:0] SV = sine_f(gi);
      assign sine_rom[gi] = SV;
   end

   // ---------------- global registers ----------------
   logic           run_q, run_d;
   logic [31:0]    sample_count_q, sample_count_d;
   logic [NCH-1:0] seen_q, seen_d;
   logic [NCH-1:0] dump_w;
   logic [31:0]    ch_rdata [NCH];
   logic [31:0]    glb_off;
   logic           glb_sel;
   logic           step;

   assign glb_off = addr - BASE;
   assign glb_sel = (glb_off < 32'hC) && (glb_off[1:0] == 2'b00);
   assign step    = PushADC & run_q;

   always_comb begin
      run_d          = run_q;
      sample_count_d = sample_count_q;
      seen_d         = seen_q;
      if (step) sample_count_d = sample_count_q + 32'd1;
      if (write && glb_sel) begin
         case (glb_off[3:2])
            2'd0:    run_d          = Wdata[0];
            2'd1:    sample_count_d = Wdata;
            2'd2:    seen_d         = seen_q & ~Wdata[NCH-1:0];
            default: ;
         endcase
      end
      // A dump on the same edge beats write-1-to-clear.
      seen_d = seen_d | dump_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q          <= 1'b0;
         sample_count_q <= '0;
         seen_q         <= '0;
      end else begin
         run_q          <= run_d;
         sample_count_q <= sample_count_d;
         seen_q         <= seen_d;
      end
   end

   assign CorrelationSeen = seen_q;

   always_comb begin
      Rdata = '0;
      if (read) begin
         if (glb_sel) begin
            case (glb_off[3:2])
               2'd0:    Rdata = {31'd0, run_q};
               2'd1:    Rdata = sample_count_q;
               2'd2:    Rdata = 32'(seen_q);
               default: Rdata = '0;
            endcase
         end
         // Channel windows never overlap each other or the global block.
         for (int c = 0; c < NCH; c++) Rdata = Rdata | ch_rdata[c];
      end
   end

   // ---------------- channels ----------------
   for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [31:0] CH_BASE = BASE + 32'h300 + 32'(gi) * 32'h40;

      logic [31:0]       ch_off;
      logic              ch_sel;
      logic [3:0]        reg_idx;
      logic [12:0]       wr_hit;
      logic              status_rd;
      logic [31:0]       rdata;

      logic [31:0]       car_add_q, car_add_d, car_phase_q, car_phase_d, car_adj_q, car_adj_d;
      logic [31:0]       chip_add_q, chip_add_d, chip_phase_q, chip_phase_d, chip_adj_q, chip_adj_d;
      logic              en_q, en_d;
      logic [LFSR_W-1:0] prn_state_q, prn_state_d, prn_poly_q, prn_poly_d;
      logic [3:0]        prn_hob_q, prn_hob_d;
      logic [31:0]       corr_cnt_q;
      logic signed [63:0] corr_q;
      logic              valid_q, ovr_q;

      logic              adv, code_bit, boundary, epoch, dump;
      logic [31:0]       car_sum, chip_sum;
      logic [LFSR_W-1:0] hob_mask, lfsr_next;

      logic [3:0]              vld_q;
      logic [14:0]             s0_phase_q;
      logic                    s0_code_q, s0_epoch_q;
      logic [31:0]             s0_cnt_q;
      logic signed [ADC_W-1:0] s0_adc_q;
      logic [15:0]             s1_sv_q;
      logic                    s1_neg_q, s1_epoch_q;
      logic [31:0]             s1_cnt_q;
      logic signed [ADC_W-1:0] s1_adc_q;
      logic signed [16:0]      s2_ref_q;
      logic                    s2_epoch_q;
      logic [31:0]             s2_cnt_q;
      logic signed [ADC_W-1:0] s2_adc_q;
      logic signed [63:0]      s3_prod_q;
      logic                    s3_epoch_q;
      logic [31:0]             s3_cnt_q;
      logic signed [63:0]      acc_q;
      logic [12:0]             sine_addr;

      assign ch_off    = addr - CH_BASE;
      assign ch_sel    = (ch_off < 32'h34) && (ch_off[1:0] == 2'b00);
      assign reg_idx   = ch_off[5:2];
      assign wr_hit    = (write && ch_sel) ? (13'd1 << reg_idx) : 13'd0;
      assign status_rd = read && ch_sel && (reg_idx == 4'd12);

      assign adv      = step & en_q;
      assign car_sum  = car_phase_q + car_add_q + car_adj_q;
      assign chip_sum = chip_phase_q + chip_add_q + chip_adj_q;
      // An hob beyond the register length selects nothing, so out reads 0.
      assign hob_mask  = LFSR_W'(1) << prn_hob_q;
      assign code_bit  = |(prn_state_q & hob_mask);
      assign lfsr_next = ((prn_state_q & ~hob_mask) << 1) ^ (code_bit ? prn_poly_q : '0);
      assign boundary  = adv & ~chip_phase_q[31] & chip_sum[31];
      assign epoch     = boundary && (lfsr_next == LFSR_W'(1));
      assign dump      = vld_q[3] & s3_epoch_q;
      assign dump_w[gi] = dump;

      // Bus writes override the step update register by register.
      always_comb begin
         car_add_d    = car_add_q;
         car_phase_d  = car_phase_q;
         car_adj_d    = car_adj_q;
         en_d         = en_q;
         chip_add_d   = chip_add_q;
         chip_phase_d = chip_phase_q;
         chip_adj_d   = chip_adj_q;
         prn_state_d  = prn_state_q;
         prn_poly_d   = prn_poly_q;
         prn_hob_d    = prn_hob_q;
         if (adv) begin
            car_phase_d  = car_sum;
            car_adj_d    = '0;
            chip_phase_d = chip_sum;
            chip_adj_d   = '0;
            if (boundary) prn_state_d = lfsr_next;
         end
         if (wr_hit[0]) car_add_d    = Wdata;
         if (wr_hit[1]) car_phase_d  = Wdata;
         if (wr_hit[2]) car_adj_d    = Wdata;
         if (wr_hit[3]) en_d         = Wdata[0];
         if (wr_hit[4]) chip_add_d   = Wdata;
         if (wr_hit[5]) chip_phase_d = Wdata;
         if (wr_hit[6]) chip_adj_d   = Wdata;
         if (wr_hit[7]) prn_state_d  = Wdata[LFSR_W-1:0];
         if (wr_hit[8]) begin
            prn_poly_d = Wdata[LFSR_W-1:0];
            prn_hob_d  = Wdata[31:28];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            car_add_q    <= '0;
            car_phase_q  <= '0;
            car_adj_q    <= '0;
            en_q         <= 1'b0;
            chip_add_q   <= '0;
            chip_phase_q <= '0;
            chip_adj_q   <= '0;
            prn_state_q  <= '0;
            prn_poly_q   <= '0;
            prn_hob_q    <= '0;
            corr_cnt_q   <= '0;
            corr_q       <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
         end else begin
            car_add_q    <= car_add_d;
            car_phase_q  <= car_phase_d;
            car_adj_q    <= car_adj_d;
            en_q         <= en_d;
            chip_add_q   <= chip_add_d;
            chip_phase_q <= chip_phase_d;
            chip_adj_q   <= chip_adj_d;
            prn_state_q  <= prn_state_d;
            prn_poly_q   <= prn_poly_d;
            prn_hob_q    <= prn_hob_d;
            if (dump) begin
               corr_cnt_q <= s3_cnt_q;
               corr_q     <= acc_q;
               valid_q    <= 1'b1;
               // A STATUS read on the dump edge leaves a clean valid flag.
               ovr_q      <= valid_q & ~status_rd;
            end else if (status_rd) begin
               valid_q <= 1'b0;
               ovr_q   <= 1'b0;
            end
         end
      end

      // Pipeline: S0 captures the sample context at the step edge, then
      // stage k+1 loads when vld_q[k] marks a sample in flight.
      assign sine_addr = s0_phase_q[13] ? ~s0_phase_q[12:0] : s0_phase_q[12:0];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q      <= '0;
            s0_phase_q <= '0;
            s0_code_q  <= 1'b0;
            s0_epoch_q <= 1'b0;
            s0_cnt_q   <= '0;
            s0_adc_q   <= '0;
            s1_sv_q    <= '0;
            s1_neg_q   <= 1'b0;
            s1_epoch_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_adc_q   <= '0;
            s2_ref_q   <= '0;
            s2_epoch_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_adc_q   <= '0;
            s3_prod_q  <= '0;
            s3_epoch_q <= 1'b0;
            s3_cnt_q   <= '0;
            acc_q      <= '0;
         end else begin
            vld_q <= {vld_q[2:0], adv};
            if (adv) begin
               s0_phase_q <= car_phase_q[31:17];
               s0_code_q  <= code_bit;
               s0_epoch_q <= epoch;
               s0_cnt_q   <= sample_count_q;
               s0_adc_q   <= ADC;
            end
            if (vld_q[0]) begin
               s1_sv_q    <= sine_rom[sine_addr];
               // Carrier half-wave sign and PRN code bit both flip the reference.
               s1_neg_q   <= s0_phase_q[14] ^ s0_code_q;
               s1_epoch_q <= s0_epoch_q;
               s1_cnt_q   <= s0_cnt_q;
               s1_adc_q   <= s0_adc_q;
            end
            if (vld_q[1]) begin
               s2_ref_q   <= s1_neg_q ? -$signed({1'b0, s1_sv_q}) : $signed({1'b0, s1_sv_q});
               s2_epoch_q <= s1_epoch_q;
               s2_cnt_q   <= s1_cnt_q;
               s2_adc_q   <= s1_adc_q;
            end
            if (vld_q[2]) begin
               s3_prod_q  <= 64'(s2_adc_q) * 64'(s2_ref_q);
               s3_epoch_q <= s2_epoch_q;
               s3_cnt_q   <= s2_cnt_q;
            end
            if (vld_q[3]) begin
               // Epoch sample opens the next integration instead of closing this one.
               acc_q <= s3_epoch_q ? s3_prod_q : acc_q + s3_prod_q;
            end
         end
      end

      always_comb begin
         rdata = '0;
         if (ch_sel) begin
            case (reg_idx)
               4'd0:    rdata = car_add_q;
               4'd1:    rdata = car_phase_q;
               4'd2:    rdata = car_adj_q;
               4'd3:    rdata = {31'd0, en_q};
               4'd4:    rdata = chip_add_q;
               4'd5:    rdata = chip_phase_q;
               4'd6:    rdata = chip_adj_q;
               4'd7:    rdata = 32'(prn_state_q);
               4'd8:    rdata = {prn_hob_q, 28'(prn_poly_q)};
               4'd9:    rdata = corr_cnt_q;
               4'd10:   rdata = corr_q[31:0];
               4'd11:   rdata = corr_q[63:32];
               4'd12:   rdata = {30'd0, ovr_q, valid_q};
               default: rdata = '0;
            endcase
         end
      end
      assign ch_rdata[gi] = rdata;
   end

endmodule
